// File: rtl/dct8_fwd_serial.sv
// Forward 8-point HEVC integer DCT, serial in / serial out.
// Accumulates the eight dot products in parallel as the samples arrive, then streams the results.
module dct8_fwd_serial #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic signed [IN_W-1:0]  s_data,
    input  logic [5:0]              shift,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [OUT_W-1:0] m_data,
    output logic [2:0]              m_index,
    output logic                    m_last
);
    localparam int ACC_W = IN_W + 10;

    localparam logic signed [ACC_W:0] HI = (2 ** (OUT_W - 1)) - 1;
    localparam logic signed [ACC_W:0] LO = -(2 ** (OUT_W - 1));

    localparam logic signed [7:0] CM [64] = '{
         64,  64,  64,  64,  64,  64,  64,  64,
         89,  75,  50,  18, -18, -50, -75, -89,
         83,  36, -36, -83, -83, -36,  36,  83,
         75, -18, -89, -50,  50,  89,  18, -75,
         64, -64, -64,  64,  64, -64, -64,  64,
         50, -89,  18,  75, -75, -18,  89, -50,
         36, -83,  83, -36, -36,  83, -83,  36,
         18, -50,  75, -89,  89, -75,  50, -18
    };

    typedef enum logic [1:0] {LOAD, ROUND, DRAIN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2:0]              n;
    logic [5:0]              sh_q;
    logic signed [ACC_W-1:0] acc  [8];
    logic signed [ACC_W-1:0] term [8];
    logic signed [ACC_W-1:0] sel_acc;
    logic [2:0]              sel_idx;
    logic                    s_fire;

    // Round-half-up, arithmetic shift, then clamp into the output range.
    // Shifts wider than the rounded sum leave only the sign.
    function automatic logic signed [OUT_W-1:0] rnd_sat(
        input logic signed [ACC_W-1:0] a,
        input logic [5:0]              sh
    );
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] q;
        sum = (ACC_W + 1)'(a);
        if (sh != 6'd0 && int'(sh) <= ACC_W)
            sum = sum + ({{ACC_W{1'b0}}, 1'b1} << (sh - 6'd1));
        if (int'(sh) > ACC_W)
            q = a[ACC_W-1] ? '1 : '0;
        else
            q = sum >>> sh;
        if (q > HI)
            q = HI;
        else if (q < LO)
            q = LO;
        return OUT_W'(q);
    endfunction

    assign s_fire  = s_valid && s_ready;
    assign m_last  = m_valid && (m_index == 3'd7);
    assign sel_idx = (state == ROUND) ? 3'd0 : 3'(m_index + 3'd1);
    assign sel_acc = acc[sel_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= LOAD;
        else
            state <= state_nxt;
    end

    // Next state and handshake outputs, decoded from state only.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        unique case (state)
            LOAD: begin
                s_ready = 1'b1;
                if (s_valid && n == 3'd7)
                    state_nxt = ROUND;
            end
            ROUND: state_nxt = DRAIN;
            DRAIN: begin
                m_valid = 1'b1;
                if (m_ready && m_index == 3'd7)
                    state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // One constant-coefficient product per output row for the current sample.
    always_comb begin
        for (int k = 0; k < 8; k++)
            term[k] = ACC_W'(CM[k * 8 + int'(n)]) * ACC_W'(s_data);
    end

    // Sample counter and per-block shift capture on the first sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            n    <= 3'd0;
            sh_q <= 6'd0;
        end else if (s_fire) begin
            n <= n + 3'd1;
            if (n == 3'd0)
                sh_q <= shift;
        end
    end

    // Accumulators restart on the first sample of each block.
    always_ff @(posedge clk) begin
        if (s_fire) begin
            for (int k = 0; k < 8; k++)
                acc[k] <= ((n == 3'd0) ? '0 : acc[k]) + term[k];
        end
    end

    // Output register: load X[0] in ROUND, advance on each accepted coefficient.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_data  <= '0;
            m_index <= 3'd0;
        end else if (state == ROUND) begin
            m_data  <= rnd_sat(sel_acc, sh_q);
            m_index <= 3'd0;
        end else if (state == DRAIN && m_ready && m_index != 3'd7) begin
            m_data  <= rnd_sat(sel_acc, sh_q);
            m_index <= m_index + 3'd1;
        end
    end

endmodule

// File: tb/tb_dct8_fwd_serial.sv
// Directed bench for dct8_fwd_serial.
// Expected coefficients come from a behavioural matrix model queued at stimulus time.
module tb_dct8_fwd_serial;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic signed [15:0] s_data;
    logic [5:0]         shift;
    logic               m_valid;
    logic               m_ready;
    logic signed [15:0] m_data;
    logic [2:0]         m_index;
    logic               m_last;

    int     npass = 0;
    int     ntot  = 0;
    longint exp_q [$];

    int CM [64] = '{
         64,  64,  64,  64,  64,  64,  64,  64,
         89,  75,  50,  18, -18, -50, -75, -89,
         83,  36, -36, -83, -83, -36,  36,  83,
         75, -18, -89, -50,  50,  89,  18, -75,
         64, -64, -64,  64,  64, -64, -64,  64,
         50, -89,  18,  75, -75, -18,  89, -50,
         36, -83,  83, -36, -36,  83, -83,  36,
         18, -50,  75, -89,  89, -75,  50, -18
    };

    dct8_fwd_serial dut (
        .clk     (clk),
        .reset   (reset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .shift   (shift),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_index (m_index),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic longint model(input int x [8], input int k, input int sh);
        longint a;
        longint r;
        a = 0;
        for (int i = 0; i < 8; i++)
            a += longint'(CM[k * 8 + i]) * longint'(x[i]);
        if (sh == 0)
            r = a;
        else if (sh > 26)
            r = (a < 0) ? -1 : 0;
        else
            r = (a + (longint'(1) <<< (sh - 1))) >>> sh;
        if (r > 32767)
            r = 32767;
        if (r < -32768)
            r = -32768;
        return r;
    endfunction

    task automatic send_block(input int x [8], input int sh, input int gap);
        for (int k = 0; k < 8; k++)
            exp_q.push_back(model(x, k, sh));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 16'(x[i]);
            shift   = (i == 0) ? 6'(sh) : 6'(sh ^ 21);
            chk("s_ready_load", s_ready, 1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_data  = 16'($urandom);
            if (i < 7)
                repeat (gap) @(posedge clk);
        end
    endtask

    task automatic recv(input int stall_k, input int stall_n);
        int     cnt;
        longint e;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!m_valid && cnt < 20);
        chk("latency", cnt, 2);
        for (int k = 0; k < 8; k++) begin
            if (k > 0)
                @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 99999;
            chk("m_valid", m_valid, 1);
            chk("m_index", m_index, k);
            chk("m_data", m_data, e);
            chk("m_last", m_last, (k == 7) ? 1 : 0);
            chk("s_ready_drain", s_ready, 0);
            if (k == stall_k) begin
                m_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("hold_valid", m_valid, 1);
                    chk("hold_index", m_index, k);
                    chk("hold_data", m_data, e);
                    chk("hold_s_ready", s_ready, 0);
                end
                m_ready = 1'b1;
            end
        end
        @(negedge clk);
        chk("post_m_valid", m_valid, 0);
        chk("post_m_last", m_last, 0);
        chk("post_s_ready", s_ready, 1);
    endtask

    initial begin
        int x [8];
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        shift   = '0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_last", m_last, 0);

        x = '{10, 10, 10, 10, 10, 10, 10, 10};
        send_block(x, 0, 0);
        recv(-1, 0);

        x = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 0, 0);
        recv(-1, 0);
        x = '{0, 0, 0, 0, 0, 0, 0, 1};
        send_block(x, 0, 0);
        recv(-1, 0);

        x = '{1, 1, 1, 1, 1, 1, 1, 1};
        send_block(x, 7, 0);
        recv(-1, 0);
        x = '{-1, -1, -1, -1, -1, -1, -1, -1};
        send_block(x, 7, 0);
        recv(-1, 0);
        x = '{3, -7, 12, 100, -250, 9, 0, -1};
        send_block(x, 0, 0);
        recv(-1, 0);
        x = '{-1, -1, -1, -1, -1, -1, -1, -1};
        send_block(x, 40, 0);
        recv(-1, 0);

        x = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        send_block(x, 0, 0);
        recv(-1, 0);
        x = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        send_block(x, 0, 0);
        recv(-1, 0);

        x = '{1, 0, 0, 0, 0, 0, 0, 0};
        send_block(x, 0, 1);
        recv(3, 5);
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++)
                x[i] = int'($urandom_range(65535)) - 32768;
            send_block(x, 4 + b, 0);
            recv(-1, 0);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = 16'(500 + i);
            shift   = 6'd3;
            @(posedge clk);
            #1;
            s_valid = 1'b0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1);
        chk("midrst_m_valid", m_valid, 0);
        x = '{10, 10, 10, 10, 10, 10, 10, 10};
        send_block(x, 0, 0);
        recv(-1, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
